// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory port arbiter.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package dmem_arb_pkg;

  // FSM encoding kept as plain constants so older tools that choke on enums still parse it.
  typedef logic [1:0] state_t;
  localparam state_t IDLE    = 2'd0;
  localparam state_t ISSUE   = 2'd1;
  localparam state_t RD_WAIT = 2'd2;

  // Requester ids; also the bit position of each port in the request vector.
  localparam logic PORT_C = 1'b0;
  localparam logic PORT_H = 1'b1;

  // Width of the read-latency down-counter (holds RD_LAT-1, RD_LAT <= 4).
  localparam int LAT_W = 2;

endpackage

// File: rtl/dmem_port_arbiter_rr_pick2.sv
// Two-way winner pick: round-robin on ties, or host-first when host_prio is set.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the pick is consumed.
//
// Ports:
//   req[1:0]  - request vector, bit PORT_C = core, bit PORT_H = host
//   last_gnt  - port granted most recently (ignored when host_prio=1)
//   host_prio - 1: host wins every tie
//   win_id    - winning port id (valid only with win_valid)
//   win_valid - at least one port is requesting
module rr_pick2
  import dmem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_gnt,
  input  logic       host_prio,
  output logic       win_id,
  output logic       win_valid
);

  always_comb begin
    win_valid = |req;
    win_id    = PORT_C;
    case (req)
      2'b01:   win_id = PORT_C;
      2'b10:   win_id = PORT_H;
      // Tie: the port that did not win last time goes next, unless host is pinned.
      2'b11:   win_id = host_prio ? PORT_H : ~last_gnt;
      default: win_id = PORT_C;
    endcase
  end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Shares the single-ported data SRAM between the core LSU (C) and host loader (H).
// Latency: gnt 1 cycle after req is sampled in IDLE; rvalid RD_LAT+1 cycles after gnt.
// Backpressure: req must be held until gnt; requests are ignored while busy.
//
// Ports:
//   clock, reset_n                  - clock and synchronous active-low reset
//   c_req/c_we/c_addr/c_wdata       - core command in; c_gnt pulses when issued
//   c_rvalid/c_rdata                - core read return (rdata held until next read)
//   h_*                             - same set for the host
//   mem_rden/mem_wren               - SRAM strobes, only ever high during ISSUE
//   mem_addr_in/mem_data_in         - SRAM write address/data
//   mem_addr_out/mem_data_out       - SRAM read address/returned data
//   busy                            - FSM is not in IDLE
module dmem_port_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 32,
  parameter int RD_LAT    = 1,
  parameter int HOST_PRIO = 0
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              c_req,
  input  logic              c_we,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [DATA_W-1:0] c_wdata,
  output logic              c_gnt,
  output logic              c_rvalid,
  output logic [DATA_W-1:0] c_rdata,
  input  logic              h_req,
  input  logic              h_we,
  input  logic [ADDR_W-1:0] h_addr,
  input  logic [DATA_W-1:0] h_wdata,
  output logic              h_gnt,
  output logic              h_rvalid,
  output logic [DATA_W-1:0] h_rdata,
  output logic              mem_rden,
  output logic              mem_wren,
  output logic [ADDR_W-1:0] mem_addr_in,
  output logic [ADDR_W-1:0] mem_addr_out,
  output logic [DATA_W-1:0] mem_data_in,
  input  logic [DATA_W-1:0] mem_data_out,
  output logic              busy
);

  state_t              state;
  logic                cmd_we;
  logic                cmd_port;
  logic [ADDR_W-1:0]   cmd_addr;
  logic [DATA_W-1:0]   cmd_wdata;
  logic [LAT_W-1:0]    lat_cnt;
  logic                last_gnt;
  logic                win_id;
  logic                win_valid;

  rr_pick2 u_pick (
    .req       ({h_req, c_req}),
    .last_gnt  (last_gnt),
    .host_prio (HOST_PRIO != 0),
    .win_id    (win_id),
    .win_valid (win_valid)
  );

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state     <= IDLE;
      cmd_we    <= 1'b0;
      cmd_port  <= PORT_C;
      cmd_addr  <= '0;
      cmd_wdata <= '0;
      lat_cnt   <= '0;
      // Pointer parked on H so the first tie after reset goes to the core.
      last_gnt  <= PORT_H;
      c_rvalid  <= 1'b0;
      h_rvalid  <= 1'b0;
      c_rdata   <= '0;
      h_rdata   <= '0;
    end else begin
      c_rvalid <= 1'b0;
      h_rvalid <= 1'b0;
      case (state)
        IDLE: begin
          if (win_valid) begin
            state    <= ISSUE;
            cmd_port <= win_id;
            last_gnt <= win_id;
            if (win_id == PORT_H) begin
              cmd_we    <= h_we;
              cmd_addr  <= h_addr;
              cmd_wdata <= h_wdata;
            end else begin
              cmd_we    <= c_we;
              cmd_addr  <= c_addr;
              cmd_wdata <= c_wdata;
            end
          end
        end
        ISSUE: begin
          if (cmd_we) begin
            state <= IDLE;
          end else begin
            state   <= RD_WAIT;
            lat_cnt <= LAT_W'(RD_LAT - 1);
          end
        end
        RD_WAIT: begin
          if (lat_cnt != '0) begin
            lat_cnt <= lat_cnt - LAT_W'(1);
          end else begin
            // SRAM output is valid this cycle; register it toward the owner.
            state <= IDLE;
            if (cmd_port == PORT_H) begin
              h_rdata  <= mem_data_out;
              h_rvalid <= 1'b1;
            end else begin
              c_rdata  <= mem_data_out;
              c_rvalid <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // SRAM strobes exist only during ISSUE; everything is zeroed otherwise so the
  // macro never sees stale addresses or data.
  always_comb begin
    mem_rden     = 1'b0;
    mem_wren     = 1'b0;
    mem_addr_in  = '0;
    mem_addr_out = '0;
    mem_data_in  = '0;
    if (state == ISSUE) begin
      if (cmd_we) begin
        mem_wren    = 1'b1;
        mem_addr_in = cmd_addr;
        mem_data_in = cmd_wdata;
      end else begin
        mem_rden     = 1'b1;
        mem_addr_out = cmd_addr;
      end
    end
  end

  assign c_gnt = (state == ISSUE) && (cmd_port == PORT_C);
  assign h_gnt = (state == ISSUE) && (cmd_port == PORT_H);
  assign busy  = (state != IDLE);

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Bench for dmem_port_arbiter: dut0 (RD_LAT=2, round-robin), dut1 (RD_LAT=4, host priority).
// Latency: n/a.
// Backpressure: n/a.
module tb_dmem_port_arbiter;

  localparam int  LAT0   = 2;
  localparam int  LAT1   = 4;
  localparam logic PC    = 1'b0;
  localparam logic PH    = 1'b1;

  typedef struct {
    int          d;
    logic        p;
    logic [31:0] data;
  } exp_t;

  logic             clock;
  logic             reset_n;
  logic [1:0]       c_req, c_we, h_req, h_we;
  logic [1:0][7:0]  c_addr, h_addr;
  logic [1:0][31:0] c_wdata, h_wdata;
  logic [1:0]       c_gnt, c_rvalid, h_gnt, h_rvalid;
  logic [1:0][31:0] c_rdata, h_rdata;
  logic [1:0]       mem_rden, mem_wren, busy;
  logic [1:0][7:0]  mem_addr_in, mem_addr_out;
  logic [1:0][31:0] mem_data_in;
  logic [31:0]      mdo0, mdo1;

  logic [31:0] sram    [2][256];
  logic [31:0] rd_pipe [2][4];
  logic [31:0] shadow  [2][256];

  exp_t        sb[$];
  int          glog[$];
  int          gcyc[$];
  logic        pend    [2][2];
  logic        exp_we  [2][2];
  logic [7:0]  exp_addr[2][2];
  logic [31:0] exp_wd  [2][2];
  int          rd_gnt_cyc[2];
  int          cyc;
  int          total;
  int          bad;
  bit          mon_en;

  dmem_port_arbiter #(.ADDR_W(8), .DATA_W(32), .RD_LAT(LAT0), .HOST_PRIO(0)) dut0 (
    .clock(clock), .reset_n(reset_n),
    .c_req(c_req[0]), .c_we(c_we[0]), .c_addr(c_addr[0]), .c_wdata(c_wdata[0]),
    .c_gnt(c_gnt[0]), .c_rvalid(c_rvalid[0]), .c_rdata(c_rdata[0]),
    .h_req(h_req[0]), .h_we(h_we[0]), .h_addr(h_addr[0]), .h_wdata(h_wdata[0]),
    .h_gnt(h_gnt[0]), .h_rvalid(h_rvalid[0]), .h_rdata(h_rdata[0]),
    .mem_rden(mem_rden[0]), .mem_wren(mem_wren[0]),
    .mem_addr_in(mem_addr_in[0]), .mem_addr_out(mem_addr_out[0]),
    .mem_data_in(mem_data_in[0]), .mem_data_out(mdo0), .busy(busy[0])
  );

  dmem_port_arbiter #(.ADDR_W(8), .DATA_W(32), .RD_LAT(LAT1), .HOST_PRIO(1)) dut1 (
    .clock(clock), .reset_n(reset_n),
    .c_req(c_req[1]), .c_we(c_we[1]), .c_addr(c_addr[1]), .c_wdata(c_wdata[1]),
    .c_gnt(c_gnt[1]), .c_rvalid(c_rvalid[1]), .c_rdata(c_rdata[1]),
    .h_req(h_req[1]), .h_we(h_we[1]), .h_addr(h_addr[1]), .h_wdata(h_wdata[1]),
    .h_gnt(h_gnt[1]), .h_rvalid(h_rvalid[1]), .h_rdata(h_rdata[1]),
    .mem_rden(mem_rden[1]), .mem_wren(mem_wren[1]),
    .mem_addr_in(mem_addr_in[1]), .mem_addr_out(mem_addr_out[1]),
    .mem_data_in(mem_data_in[1]), .mem_data_out(mdo1), .busy(busy[1])
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // SRAM models: address sampled at the edge closing the issue cycle, data
  // appears RD_LAT cycles after the issue cycle.
  always @(posedge clock) begin
    for (int d = 0; d < 2; d++) begin
      if (mem_wren[d]) sram[d][mem_addr_in[d]] <= mem_data_in[d];
      rd_pipe[d][0] <= sram[d][mem_addr_out[d]];
      for (int i = 1; i < 4; i++) rd_pipe[d][i] <= rd_pipe[d][i-1];
    end
  end
  assign mdo0 = rd_pipe[0][LAT0-1];
  assign mdo1 = rd_pipe[1][LAT1-1];

  function automatic int lat_of(input int d);
    return (d == 0) ? LAT0 : LAT1;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input int d);
    chk("zero_outs",
        128'({c_gnt[d], c_rvalid[d], c_rdata[d], h_gnt[d], h_rvalid[d], h_rdata[d],
              mem_rden[d], mem_wren[d], mem_addr_in[d], mem_addr_out[d],
              mem_data_in[d], busy[d]}),
        128'(0));
  endtask

  task automatic mon(input int d);
    logic [1:0]  g;
    logic        p;
    logic [49:0] got_mem;
    logic [49:0] exp_mem;
    exp_t        e;
    g       = {h_gnt[d], c_gnt[d]};
    got_mem = {mem_rden[d], mem_wren[d], mem_addr_in[d], mem_addr_out[d], mem_data_in[d]};
    exp_mem = '0;
    chk("dual_gnt", 128'(g == 2'b11), 128'(0));
    if (g != 2'b00) begin
      p = h_gnt[d];
      chk("gnt_owner", 128'(pend[d][p]), 128'(1));
      pend[d][p] = 1'b0;
      glog.push_back(d * 2 + int'(p));
      gcyc.push_back(cyc);
      if (exp_we[d][p]) begin
        exp_mem = {1'b0, 1'b1, exp_addr[d][p], 8'h00, exp_wd[d][p]};
      end else begin
        exp_mem = {1'b1, 1'b0, 8'h00, exp_addr[d][p], 32'h0};
        rd_gnt_cyc[d] = cyc;
      end
    end
    chk("mem_cmd", 128'(got_mem), 128'(exp_mem));
    if (c_rvalid[d] || h_rvalid[d]) begin
      if (sb.size() == 0 || sb[0].d != d) begin
        chk("rvalid_unexp", 128'({c_rvalid[d], h_rvalid[d]}), 128'(0));
      end else begin
        e = sb.pop_front();
        chk("rv_port", 128'({c_rvalid[d], h_rvalid[d]}), 128'(e.p ? 2'b01 : 2'b10));
        chk("rdata", 128'(e.p ? h_rdata[d] : c_rdata[d]), 128'(e.data));
        chk("rv_latency", 128'(cyc - rd_gnt_cyc[d]), 128'(lat_of(d) + 1));
      end
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    cyc++;
    if (mon_en) begin
      for (int d = 0; d < 2; d++) mon(d);
    end
  endtask

  task automatic drive(input int d, input logic p, input logic req, input logic we,
                       input logic [7:0] a, input logic [31:0] wd);
    if (p) begin
      h_req[d] = req; h_we[d] = we; h_addr[d] = a; h_wdata[d] = wd;
    end else begin
      c_req[d] = req; c_we[d] = we; c_addr[d] = a; c_wdata[d] = wd;
    end
    if (req) begin
      pend[d][p]     = 1'b1;
      exp_we[d][p]   = we;
      exp_addr[d][p] = a;
      exp_wd[d][p]   = wd;
    end
  endtask

  // Raise a request, hold it until granted, and drop it in the grant cycle.
  task automatic do_req(input int d, input logic p, input logic we, input logic [7:0] a,
                        input logic [31:0] wd, input bit push, output int n);
    exp_t e;
    drive(d, p, 1'b1, we, a, wd);
    if (we) begin
      shadow[d][a] = wd;
    end else if (push) begin
      e.d = d; e.p = p; e.data = shadow[d][a];
      sb.push_back(e);
    end
    n = 0;
    while (pend[d][p] && n < 50) begin
      tick();
      n++;
    end
    drive(d, p, 1'b0, we, a, wd);
    if (pend[d][p]) begin
      chk("gnt_timeout", 128'(pend[d][p]), 128'(0));
      pend[d][p] = 1'b0;
    end
  endtask

  task automatic read_chk(input int d, input logic p, input logic [7:0] a);
    int n;
    do_req(d, p, 1'b0, a, 32'h0, 1'b1, n);
    chk("busy_issue", 128'(busy[d]), 128'(1));
    for (int k = 1; k <= lat_of(d); k++) begin
      tick();
      chk("busy_wait", 128'(busy[d]), 128'(1));
    end
    tick();
    chk("busy_done", 128'(busy[d]), 128'(0));
    chk("rd_drained", 128'(sb.size()), 128'(0));
  endtask

  initial begin
    int         n;
    logic [7:0] ord;
    total = 0; bad = 0; cyc = 0; mon_en = 1'b0;
    reset_n = 1'b0;
    c_req = '0; c_we = '0; c_addr = '0; c_wdata = '0;
    h_req = '0; h_we = '0; h_addr = '0; h_wdata = '0;
    for (int d = 0; d < 2; d++) begin
      rd_gnt_cyc[d] = 0;
      for (int p = 0; p < 2; p++) begin
        pend[d][p] = 1'b0; exp_we[d][p] = 1'b0; exp_addr[d][p] = '0; exp_wd[d][p] = '0;
      end
    end

    // Power-on reset.
    tick(); tick(); tick();
    mon_en = 1'b1;
    chk_zero(0);
    chk_zero(1);
    reset_n = 1'b1;
    tick();

    // Host write then core read-back on dut0.
    do_req(0, PH, 1'b1, 8'h05, 32'hDEADBEEF, 1'b0, n);
    chk("wr_gnt_lat", 128'(n), 128'(1));
    tick();
    read_chk(0, PC, 8'h05);

    // Reset while a core read sits in RD_WAIT: the read must vanish.
    do_req(0, PC, 1'b0, 8'h10, 32'h0, 1'b0, n);
    tick();
    reset_n = 1'b0;
    tick();
    chk_zero(0);
    reset_n = 1'b1;
    for (int i = 0; i < 5; i++) tick();

    // Both ports held on dut0: strict alternation starting with the core.
    drive(0, PC, 1'b1, 1'b1, 8'h20, 32'h11111111);
    drive(0, PH, 1'b1, 1'b1, 8'h21, 32'h22222222);
    shadow[0][8'h20] = 32'h11111111;
    shadow[0][8'h21] = 32'h22222222;
    glog.delete(); gcyc.delete(); n = 0;
    while (glog.size() < 4 && n < 40) begin
      tick();
      n++;
      pend[0][0] = 1'b1;
      pend[0][1] = 1'b1;
    end
    drive(0, PC, 1'b0, 1'b1, 8'h20, 32'h11111111);
    drive(0, PH, 1'b0, 1'b1, 8'h21, 32'h22222222);
    pend[0][0] = 1'b0; pend[0][1] = 1'b0;
    if (glog.size() == 4) begin
      ord = {2'(glog[0]), 2'(glog[1]), 2'(glog[2]), 2'(glog[3])};
      chk("rr_order", 128'(ord), 128'(8'b00_01_00_01));
      for (int i = 1; i < 4; i++) chk("rr_spacing", 128'(gcyc[i] - gcyc[i-1]), 128'(2));
    end else begin
      chk("rr_count", 128'(glog.size()), 128'(4));
    end
    tick();

    // Core request pulsed for one cycle while a host read is in flight.
    do_req(0, PH, 1'b0, 8'h21, 32'h0, 1'b1, n);
    c_req[0] = 1'b1; c_we[0] = 1'b0; c_addr[0] = 8'h40;
    tick();
    c_req[0] = 1'b0;
    n = 0;
    while (sb.size() != 0 && n < 20) begin
      tick();
      n++;
    end
    chk("wd_drain", 128'(sb.size()), 128'(0));
    tick(); tick();
    chk("wd_idle", 128'(busy[0]), 128'(0));

    // Host priority on dut1: host keeps winning until it lets go.
    drive(1, PC, 1'b1, 1'b1, 8'h30, 32'h33333333);
    drive(1, PH, 1'b1, 1'b1, 8'h31, 32'h44444444);
    shadow[1][8'h30] = 32'h33333333;
    shadow[1][8'h31] = 32'h44444444;
    glog.delete(); gcyc.delete(); n = 0;
    while (glog.size() < 4 && n < 60) begin
      tick();
      n++;
      pend[1][0] = 1'b1;
      if (glog.size() < 3) pend[1][1] = 1'b1;
      else if (h_req[1]) drive(1, PH, 1'b0, 1'b1, 8'h31, 32'h44444444);
    end
    drive(1, PC, 1'b0, 1'b1, 8'h30, 32'h33333333);
    drive(1, PH, 1'b0, 1'b1, 8'h31, 32'h44444444);
    pend[1][0] = 1'b0; pend[1][1] = 1'b0;
    if (glog.size() == 4) begin
      ord = {2'(glog[0]), 2'(glog[1]), 2'(glog[2]), 2'(glog[3])};
      chk("prio_order", 128'(ord), 128'(8'b11_11_11_10));
    end else begin
      chk("prio_count", 128'(glog.size()), 128'(4));
    end
    tick();

    // RD_LAT=4 sweep on dut1: preload addr*3 then read each back.
    for (int i = 0; i < 8; i++) do_req(1, PH, 1'b1, 8'(i), 32'(i * 3), 1'b0, n);
    tick();
    for (int i = 0; i < 8; i++) read_chk(1, PH, 8'(i));

    tick();
    chk("sb_empty", 128'(sb.size()), 128'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dmem_port_arbiter.md
Name: dmem_port_arbiter

Overview:
- Shares the single-ported 32-bit data SRAM between two requesters: the core load/store unit (port C) and the external host loader/debug port (port H).
- Uses a registered request/grant handshake. Each granted access is issued to the SRAM for exactly one cycle, and read data is returned with a valid pulse.
- Sits between the core/host and the data-memory instance, replacing the ad-hoc write_data/read_data muxing on that memory's ports.

Parameters:
- ADDR_W, 8, SRAM word address width.
- DATA_W, 32, data width.
- RD_LAT, 1, SRAM read latency in clocks from the issue cycle; legal range 1..4.
- HOST_PRIO, 0, arbitration mode: 0 = round-robin, 1 = fixed priority to host.

Ports:
- clock  in  1  system clock.
- reset_n  in  1  reset, synchronous, active-low.
- c_req  in  1  core request; hold stable with its fields until c_gnt.
- c_we  in  1  core access type: 1 = write, 0 = read.
- c_addr  in  ADDR_W  core word address.
- c_wdata  in  DATA_W  core write data.
- c_gnt  out  1  one-cycle pulse: core command issued to SRAM this cycle.
- c_rvalid  out  1  one-cycle pulse: c_rdata is valid.
- c_rdata  out  DATA_W  core read data.
- h_req, h_we, h_addr, h_wdata, h_gnt, h_rvalid, h_rdata: same as the core signals, for the host.
- mem_rden  out  1  SRAM read enable.
- mem_wren  out  1  SRAM write enable.
- mem_addr_in  out  ADDR_W  SRAM write address.
- mem_addr_out  out  ADDR_W  SRAM read address.
- mem_data_in  out  DATA_W  SRAM write data.
- mem_data_out  in  DATA_W  SRAM read data.
- busy  out  1  high whenever state is not IDLE.

Behaviour:
- Reset (synchronous, reset_n low at a rising edge):
  - State goes to IDLE; all command registers clear.
  - All outputs are 0, including rdata registers.
  - RR pointer last_gnt = H, so the core wins the first tie.
  - A read in flight is dropped; no rvalid is produced.
- States: IDLE, ISSUE, RD_WAIT.
- IDLE:
  - Arbitration is combinational on c_req/h_req. If neither requests, stay in IDLE.
  - Otherwise the winner's we/addr/wdata and its port id are captured into registers at the edge, and the state moves to ISSUE.
  - Round-robin: if both request, the port not equal to last_gnt wins; last_gnt updates to the winner.
  - HOST_PRIO=1: host wins every tie; last_gnt is still tracked but ignored.
- ISSUE (exactly 1 cycle):
  - mem_* outputs are driven from the registers.
  - Write: mem_wren=1, mem_addr_in=addr, mem_data_in=wdata. Next state IDLE.
  - Read: mem_rden=1, mem_addr_out=addr. Load lat_cnt=RD_LAT-1 and go to RD_WAIT.
  - The winner's gnt pulses high in this cycle. The requester may drop or change its req in the following cycle.
- RD_WAIT:
  - While lat_cnt is nonzero, decrement it.
  - When lat_cnt reaches 0, capture mem_data_out into the owner's rdata register and go to IDLE.
  - The owner's rvalid pulses in the next cycle, i.e. RD_LAT+1 cycles after gnt.
- rdata registers hold their last value until overwritten. rvalid is high for exactly 1 cycle per read.
- Outside ISSUE: mem_rden=0, mem_wren=0, mem addresses and data are 0. Never assert mem_rden and mem_wren together.
- Latency:
  - Write: gnt 1 cycle after req is seen in IDLE.
  - Read: rvalid RD_LAT+2 cycles after req is sampled.
  - Throughput: a write every 2 cycles, a read every RD_LAT+2 cycles.
- Requests arriving while busy are not sampled; they wait for IDLE. No request is lost if req is held.
- A req deasserted before it is granted is simply not served; there is no stale grant.
- A grant back to the same port is allowed when the other port is idle.
- An RR starvation bound holds: with both ports continuously requesting, grants strictly alternate.
- Addresses are used unmodified (no wrap or bounds logic); ADDR_W bits pass straight to the SRAM.

Decomposition:
- Package dmem_arb_pkg holds:
  - state enum {IDLE, ISSUE, RD_WAIT};
  - port ids PORT_C=1'b0, PORT_H=1'b1;
  - localparam LAT_W=2.
- One natural sub-module, rr_pick2: 2-way round-robin/fixed-priority pick.
  - Inputs: req[1:0], last_gnt, host_prio.
  - Output: winner id and win_valid.
  - Purely combinational, unit-testable.
- Command registers, FSM and latency counter live in the top.

Test Plan:
- Reset mid-read:
  - Stimulus: core read addr 0x10 granted, then reset_n=0 during RD_WAIT (RD_LAT=2).
  - Required: no c_rvalid; all outputs 0 the cycle after reset; next tie goes to core.
- Single host write then core read:
  - Stimulus: host writes 0xDEADBEEF to addr 0x05; then core reads 0x05.
  - Required: h_gnt with mem_wren=1, mem_addr_in=0x05; c_rvalid RD_LAT+1 cycles after c_gnt with c_rdata=0xDEADBEEF.
- Simultaneous requests, HOST_PRIO=0:
  - Stimulus: both held high for 4 transactions (all writes).
  - Required: grant order C,H,C,H; gnt pulses 2 cycles apart; never two gnts in one cycle.
- HOST_PRIO=1 contention:
  - Stimulus: both requests held.
  - Required: every grant goes to H while h_req=1; core is granted only after h_req drops.
- Request withdrawn:
  - Stimulus: c_req high for 1 cycle while busy with a host read, then low.
  - Required: no c_gnt, no SRAM access for the core; state returns to IDLE.
- RD_LAT=4 sweep:
  - Stimulus: host reads back 8 addresses 0x00..0x07, preloaded with addr*3.
  - Required: each h_rvalid arrives exactly 5 cycles after its h_gnt with correct data; busy stays high from ISSUE through RD_WAIT.
